// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_scan_ctrl : drives 4:1 mux select, samples Y per channel, streams     |
// |                 (channel, sample) over valid/ready; channel skip with     |
// |                 SCAN_SKIP_EN.                                             |
// | Revision      : 1.0  initial release                                      |
// +--------------------------------------------------------------------------+
module mux_scan_ctrl #(
   parameter int W          = 1,
   parameter int SETTLE_CYC = 1,
   parameter int FRAMES     = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [3:0]   ch_en,
   input  logic [W-1:0] y_in,
   output logic [1:0]   sel,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   out_ch,
   output logic         busy,
   output logic         done
);

   localparam logic [3:0] c_settle_last = 4'(SETTLE_CYC - 1);
   localparam logic [7:0] c_frames      = 8'(FRAMES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   state_t         state_q;
   logic [3:0]     en_q;
   logic [3:0]     settle_q;
   logic [7:0]     frame_q;
   logic [1:0]     sel_q;
   logic           out_valid_q;
   logic [W-1:0]   out_data_q;
   logic [1:0]     out_ch_q;
   logic           busy_q;
   logic           done_q;

   logic [3:0]     w_start_mask;
   logic [3:0]     w_pick_mask;
   logic [2:0]     w_from;
   logic [2:0]     w_first;
   logic [2:0]     w_next;

   // Returns {found, index} of the lowest set mask bit at or above 'from'.
   function automatic logic [2:0] f_pick(input logic [3:0] mask, input logic [2:0] from);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i] && (3'(i) >= from)) begin
            r = {1'b1, 2'(i)};
         end
      end
      return r;
   endfunction

`ifdef SCAN_SKIP_EN
   assign w_start_mask = ch_en;
`else
   assign w_start_mask = ch_en | 4'b1111;
`endif

   // In IDLE the candidate mask is the incoming one; otherwise the latched one.
   assign w_pick_mask = (state_q == S_IDLE) ? w_start_mask : en_q;
   assign w_first     = f_pick(w_pick_mask, 3'd0);
   assign w_from      = {1'b0, sel_q} + 3'd1;
   assign w_next      = f_pick(en_q, w_from);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         en_q        <= 4'd0;
         settle_q    <= 4'd0;
         frame_q     <= 8'd0;
         sel_q       <= 2'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= 2'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  en_q     <= w_start_mask;
                  frame_q  <= 8'd0;
                  settle_q <= 4'd0;
                  if (w_first[2]) begin
                     sel_q   <= w_first[1:0];
                     busy_q  <= 1'b1;
                     state_q <= S_SETTLE;
                  end else begin
                     done_q  <= 1'b1;
                  end
               end
            end
            S_SETTLE: begin
               if (settle_q == c_settle_last) begin
                  settle_q    <= 4'd0;
                  out_data_q  <= y_in;
                  out_ch_q    <= sel_q;
                  out_valid_q <= 1'b1;
                  state_q     <= S_HOLD;
               end else begin
                  settle_q <= settle_q + 4'd1;
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (w_next[2]) begin
                     sel_q   <= w_next[1:0];
                     state_q <= S_SETTLE;
                  end else if ((frame_q + 8'd1) < c_frames) begin
                     frame_q <= frame_q + 8'd1;
                     sel_q   <= w_first[1:0];
                     state_q <= S_SETTLE;
                  end else begin
                     frame_q <= frame_q + 8'd1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign sel       = sel_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire
